alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single parameterized ALU (add, OR-reduce, AND-reduce, concatenate) between two requesters. Round-robin arbitration selects one request, latches its operands, runs the ALU for one cycle, and holds the registered result until the consumer acknowledges it. The block sits between two datapath clients and one ALU instance, so that neither client needs its own ALU.

## Interface
- N, default 4: operand width; result width is 2N.

- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  2  request from each requester; bit i belongs to requester i. Held high until Grant[i] is seen.
- A0, B0  in  N  operands, requester 0. Held stable while Req[0] is high.
- F0  in  3  function code, requester 0.
- A1, B1  in  N  operands, requester 1.
- F1  in  3  function code, requester 1.
- Grant  out  2  one-hot, one-cycle pulse marking the accepted request.
- Busy  out  1  high whenever the FSM is not in IDLE.
- ResValid  out  1  a result is held on Result/ResId.
- ResId  out  1  index of the requester that owns Result.
- Result  out  2N  registered ALU result.
- ResAck  in  1  consumer accepts the result; meaningful only while ResValid is high.

## Operation
- The FSM has three states: IDLE, EXEC and DONE.
- IDLE:
  - If Req is nonzero, the arbiter picks a winner and drives Grant combinationally in the same cycle.
  - Operands and function of the winner are latched at the clock edge; the FSM moves to EXEC.
  - The round-robin pointer Last is set to the winner's index.
- Arbitration:
  - A single requester wins unconditionally.
  - If both requesters are active, the one not equal to Last wins.
- EXEC:
  - The ALU evaluates the latched operands.
  - Result and ResId are registered at the end of the cycle; the FSM moves to DONE.
- DONE:
  - ResValid is 1; Result and ResId are held stable.
  - If ResAck = 1, the FSM moves to IDLE. No grant is issued in that same cycle.
  - If ResAck = 0, the FSM stays in DONE indefinitely.
- Requests are ignored in EXEC and DONE: Grant = 0, and the requester keeps Req asserted.
- ResAck outside DONE is ignored.
- ALU functions (operands zero-extended to 2N):
  - 0: A + B, with the carry kept in bit N.
  - 1: OR-reduce of {A,B}, a 1-bit value zero-extended.
  - 2: AND-reduce of {A,B}, a 1-bit value zero-extended.
  - 3: concatenation {A,B}, with A in the upper half.
  - 4–7: result 0.
- Reset values: state IDLE, Last = 1 (requester 0 wins the first contention), Grant = 0, Busy = 0, ResValid = 0, ResId = 0, Result = 0, operand latches = 0.
- Reset in any state, including EXEC or DONE, abandons the operation. The result is discarded and is not presented.

## Timing
- Grant asserts in cycle t, the IDLE cycle with an active Req.
- EXEC is cycle t+1.
- ResValid rises in cycle t+2.
- The earliest next Grant is in the cycle after the ResAck cycle.
- Minimum spacing between grants is 3 cycles.
- Busy = 1 in cycles t+1 through the ResAck cycle inclusive.
- Grant is the only combinational output. All other outputs come directly from registers.

## Structure
- Package alu_pkg holds:
  - the state typedef enum {IDLE, EXEC, DONE};
  - function constants ALU_ADD = 3'd0, ALU_OR = 3'd1, ALU_AND = 3'd2, ALU_CAT = 3'd3.
- Sub-module alu_core (parameter N) is the purely combinational ALU. alu_arbiter instantiates it once, fed from the operand latches.

## Test plan
- After reset, Req = 2'b01, A0 = 4'hF, B0 = 4'h1, F0 = 0:
  - Grant = 2'b01 in that cycle.
  - Two cycles later: ResValid = 1, Result = 8'h10, ResId = 0.
- Req = 2'b11 held continuously with ResAck pulsed whenever ResValid = 1:
  - The grant order starting from reset is 0, 1, 0, 1.
  - Each Result matches the owning requester's operands.
- Function sweep via requester 1:
  - F = 1, A = 0, B = 0 → Result = 0.
  - F = 1, B = 4'h2 → Result = 1.
  - F = 2, A = B = 4'hF → Result = 1.
  - F = 3, A = 4'hA, B = 4'h5 → Result = 8'hA5.
  - F = 5 → Result = 0.
- ResAck held low for 10 cycles while ResValid = 1 and Req = 2'b10:
  - Result, ResId and ResValid stay stable.
  - Grant stays 0.
  - Grant = 2'b10 appears one cycle after ResAck.
- Reset asserted during EXEC:
  - The next cycle, all outputs are 0 and Busy = 0.
  - A following Req = 2'b11 grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and ALU function codes for the arbitrated ALU slice.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_CAT = 3'd3;

    // Winner index for a non-zero request vector; on contention the
    // requester that did not win last time goes first.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: add, OR-reduce, AND-reduce, concatenate.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2:0]     f,
    output logic [2*N-1:0] y
);

    always_comb begin
        y = '0;
        case (f)
            ALU_ADD: y = {{N{1'b0}}, a} + {{N{1'b0}}, b};
            ALU_OR:  y[0] = |{a, b};
            ALU_AND: y[0] = &{a, b};
            ALU_CAT: y = {a, b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core between two requesters; the
// result is held until the consumer acknowledges it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [1:0]     Req,
    input  logic [N-1:0]   A0,
    input  logic [N-1:0]   B0,
    input  logic [2:0]     F0,
    input  logic [N-1:0]   A1,
    input  logic [N-1:0]   B1,
    input  logic [2:0]     F1,
    output logic [1:0]     Grant,
    output logic           Busy,
    output logic           ResValid,
    output logic           ResId,
    output logic [2*N-1:0] Result,
    input  logic           ResAck
);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           owner_q, owner_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2:0]     f_q, f_d;
    logic           busy_q, busy_d;
    logic           res_valid_q, res_valid_d;
    logic           res_id_q, res_id_d;
    logic [2*N-1:0] result_q, result_d;
    logic [2*N-1:0] alu_y;
    logic [1:0]     grant_c;
    logic           win;

    alu_core #(.N(N)) u_alu (
        .a (a_q),
        .b (b_q),
        .f (f_q),
        .y (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        f_d         = f_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        result_d    = result_q;
        grant_c     = '0;
        win         = rr_pick(Req, last_q);

        case (state_q)
            IDLE: begin
                if (Req != 2'b00) begin
                    grant_c = win ? 2'b10 : 2'b01;
                    a_d     = win ? A1 : A0;
                    b_d     = win ? B1 : B0;
                    f_d     = win ? F1 : F0;
                    owner_d = win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_y;
                res_id_d    = owner_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Returning to IDLE here means the next grant is one cycle later.
                if (ResAck) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            f_q         <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f_q         <= f_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            result_q    <= result_d;
        end
    end

    assign Grant    = grant_c;
    assign Busy     = busy_q;
    assign ResValid = res_valid_q;
    assign ResId    = res_id_q;
    assign Result   = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter, checked against a
// transaction-level model of arbitration order and ALU arithmetic.
module tb_alu_arbiter;

    localparam int N = 4;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [1:0]     Req;
    logic [N-1:0]   A0, B0, A1, B1;
    logic [2:0]     F0, F1;
    logic [1:0]     Grant;
    logic           Busy;
    logic           ResValid;
    logic           ResId;
    logic [2*N-1:0] Result;
    logic           ResAck;

    int n_cmp = 0;
    int n_bad = 0;
    int last_m = 1;

    always #5 Clock = ~Clock;

    alu_arbiter #(.N(N)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (Req),
        .A0       (A0),
        .B0       (B0),
        .F0       (F0),
        .A1       (A1),
        .B1       (B1),
        .F1       (F1),
        .Grant    (Grant),
        .Busy     (Busy),
        .ResValid (ResValid),
        .ResId    (ResId),
        .Result   (Result),
        .ResAck   (ResAck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU written directly from the function table.
    function automatic int unsigned ref_alu(input int f, input int unsigned a, input int unsigned b);
        case (f)
            0: return a + b;
            1: return (a != 0 || b != 0) ? 1 : 0;
            2: return (a == 15 && b == 15) ? 1 : 0;
            3: return a * 16 + b;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One complete transaction from an IDLE cycle: grant, exec, result,
    // a hold of 'hold' cycles without ack, then the ack cycle.
    task automatic txn(input logic [1:0] req, input int hold, input bit keep, input int exp_win);
        int w;
        int unsigned exp_res;
        Req = req;
        #1;
        if (req == 2'b11) w = (last_m == 0) ? 1 : 0;
        else w = (req == 2'b10) ? 1 : 0;
        if (exp_win >= 0) chk("order", 32'(w), 32'(exp_win));
        chk("grant", 32'(Grant), 32'(1 << w));
        chk("busy_t", 32'(Busy), 32'd0);
        exp_res = (w == 1) ? ref_alu(int'(F1), int'(A1), int'(B1))
                           : ref_alu(int'(F0), int'(A0), int'(B0));
        last_m = w;
        tick();
        // Winner is free to change its operands now; stray ack is ignored.
        if (!keep) Req = 2'b00;
        if (w == 1) begin A1 = 4'($urandom); B1 = 4'($urandom); end
        else begin A0 = 4'($urandom); B0 = 4'($urandom); end
        ResAck = 1'($urandom);
        #1;
        chk("exec_grant", 32'(Grant), 32'd0);
        chk("exec_busy", 32'(Busy), 32'd1);
        chk("exec_valid", 32'(ResValid), 32'd0);
        tick();
        ResAck = 1'b0;
        chk("done_valid", 32'(ResValid), 32'd1);
        chk("done_result", 32'(Result), exp_res);
        chk("done_id", 32'(ResId), 32'(w));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_grant", 32'(Grant), 32'd0);
            chk("hold_valid", 32'(ResValid), 32'd1);
            chk("hold_result", 32'(Result), exp_res);
            chk("hold_id", 32'(ResId), 32'(w));
            chk("hold_busy", 32'(Busy), 32'd1);
        end
        ResAck = 1'b1;
        #1;
        chk("ack_grant", 32'(Grant), 32'd0);
        tick();
        ResAck = 1'b0;
        chk("post_valid", 32'(ResValid), 32'd0);
        chk("post_busy", 32'(Busy), 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req = 2'b00;
        ResAck = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        last_m = 1;
    endtask

    initial begin
        logic [2:0] sw_f [5];
        logic [3:0] sw_a [5];
        logic [3:0] sw_b [5];
        logic [1:0] r;
        sw_f = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd5};
        sw_a = '{4'h0, 4'h0, 4'hF, 4'hA, 4'h7};
        sw_b = '{4'h0, 4'h2, 4'hF, 4'h5, 4'h9};
        A0 = '0; B0 = '0; F0 = '0; A1 = '0; B1 = '0; F1 = '0;

        // Reset state
        do_reset();
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(ResValid), 32'd0);
        chk("rst_id", 32'(ResId), 32'd0);
        chk("rst_result", 32'(Result), 32'd0);

        // First add with carry into bit N
        A0 = 4'hF; B0 = 4'h1; F0 = 3'd0;
        txn(2'b01, 0, 1'b0, 0);

        // Round-robin under continuous contention from reset
        do_reset();
        F0 = 3'd0; F1 = 3'd3;
        A0 = 4'($urandom); B0 = 4'($urandom); A1 = 4'($urandom); B1 = 4'($urandom);
        txn(2'b11, 0, 1'b1, 0);
        txn(2'b11, 1, 1'b1, 1);
        txn(2'b11, 0, 1'b1, 0);
        txn(2'b11, 2, 1'b1, 1);
        Req = 2'b00;

        // Function sweep through requester 1
        for (int i = 0; i < 5; i++) begin
            F1 = sw_f[i]; A1 = sw_a[i]; B1 = sw_b[i];
            txn(2'b10, 0, 1'b0, 1);
        end

        // Long hold without ack, then an immediate re-grant
        F1 = 3'd3; A1 = 4'h3; B1 = 4'hC;
        txn(2'b10, 10, 1'b1, 1);
        txn(2'b10, 0, 1'b0, 1);

        // Reset while in EXEC abandons the operation
        Req = 2'b11;
        tick();
        Req = 2'b00;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        last_m = 1;
        chk("rexec_grant", 32'(Grant), 32'd0);
        chk("rexec_busy", 32'(Busy), 32'd0);
        chk("rexec_valid", 32'(ResValid), 32'd0);
        chk("rexec_id", 32'(ResId), 32'd0);
        chk("rexec_result", 32'(Result), 32'd0);
        tick();
        chk("rexec_idle_valid", 32'(ResValid), 32'd0);
        txn(2'b11, 0, 1'b0, 0);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            r = 2'($urandom_range(1, 3));
            F0 = 3'($urandom); F1 = 3'($urandom);
            A0 = 4'($urandom); B0 = 4'($urandom);
            A1 = 4'($urandom); B1 = 4'($urandom);
            txn(r, int'($urandom_range(0, 3)), 1'($urandom), -1);
            if ($urandom_range(0, 1) == 1) begin
                Req = 2'b00;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
